// File: rtl/if_stage_if.sv
// if_stage_if
//   Bundles the fetch-stage handshake signals: the decode-facing
//   pc/inst/if_id_rdy stream, the EX redirect, decode back-pressure,
//   the global ready and the byte-wide fetch port of the memory controller.
//   Modports:
//     master : the fetch stage (drives pc_o, inst_o, if_id_rdy, mem_req, mem_addr)
//     slave  : the surroundings (drive rdy, jump_or_not, jump_addr, id_stall,
//              mem_ack, mem_data)
interface if_stage_if;
  logic        rdy;
  logic        jump_or_not;
  logic [31:0] jump_addr;
  logic        id_stall;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        if_id_rdy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;

  modport master (
    input  rdy, jump_or_not, jump_addr, id_stall, mem_ack, mem_data,
    output pc_o, inst_o, if_id_rdy, mem_req, mem_addr
  );

  modport slave (
    output rdy, jump_or_not, jump_addr, id_stall, mem_ack, mem_data,
    input  pc_o, inst_o, if_id_rdy, mem_req, mem_addr
  );
endinterface

// File: rtl/if_stage.sv
// if_stage
//   RV32I instruction-fetch stage. Looks the current pc up in a direct-mapped
//   instruction cache (one word per entry); on a miss it fetches the word as
//   four little-endian byte reads, fills the cache and presents the word.
//   The presented instruction is held until decode accepts it (id_stall = 0),
//   after which pc advances by 4. A redirect from EX overrides everything but
//   reset and discards any partially fetched word.
//   Ports:
//     clk : clock, all state changes on the rising edge
//     rst : asynchronous, active-high reset
//     bus : if_stage_if.master (rdy, redirect, back-pressure, decode stream,
//           memory fetch port)
module if_stage #(
  parameter int          ICACHE_INDEX_BITS = 7,
  parameter logic [31:0] RESET_PC          = 32'h0
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);

  localparam int IDX_W = ICACHE_INDEX_BITS;
  localparam int TAG_W = 30 - ICACHE_INDEX_BITS;
  localparam int DEPTH = 1 << ICACHE_INDEX_BITS;
  localparam int ENT_W = TAG_W + 32;

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_FETCH  = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_pc_o, w_pc_o_next;
  logic [31:0] r_inst_o, w_inst_o_next;
  logic        r_if_id_rdy, w_if_id_rdy_next;
  logic        r_mem_req, w_mem_req_next;
  logic [31:0] r_mem_addr, w_mem_addr_next;
  logic [1:0]  r_byte_cnt, w_byte_cnt_next;
  // Only the first three bytes are buffered; the fourth goes straight into the word.
  logic [23:0] r_buf;

  logic             r_valid [DEPTH];
  logic [ENT_W-1:0] r_cache [DEPTH];
  logic [ENT_W-1:0] r_rd_entry;
  logic             r_rd_valid;

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_byte_ack;
  logic             w_fill;
  logic [31:0]      w_word;
  logic [31:0]      w_jump_pc;

  assign w_idx     = r_pc[IDX_W+1:2];
  assign w_tag     = r_pc[31:IDX_W+2];
  // The cache read is registered, so it is addressed with the pc that will be
  // current next cycle; in LOOKUP the read data then belongs to r_pc.
  assign w_rd_idx  = w_pc_next[IDX_W+1:2];
  assign w_hit     = r_rd_valid && (r_rd_entry[ENT_W-1:32] == w_tag);
  assign w_byte_ack = (r_state == S_FETCH) && bus.mem_ack && !bus.jump_or_not;
  assign w_fill    = w_byte_ack && (r_byte_cnt == 2'd3);
  assign w_word    = {bus.mem_data, r_buf};
  assign w_jump_pc = bus.jump_addr & ~32'h3;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOOKUP;
    end else if (bus.rdy) begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    if (bus.jump_or_not) begin
      w_state_next = S_LOOKUP;
    end else begin
      case (r_state)
        S_LOOKUP: w_state_next = w_hit ? S_HOLD : S_FETCH;
        S_FETCH:  if (bus.mem_ack && (r_byte_cnt == 2'd3)) w_state_next = S_HOLD;
        S_HOLD:   if (!bus.id_stall) w_state_next = S_LOOKUP;
        default:  w_state_next = S_LOOKUP;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs / datapath next values
  always_comb begin
    w_pc_next        = r_pc;
    w_pc_o_next      = r_pc_o;
    w_inst_o_next    = r_inst_o;
    w_if_id_rdy_next = r_if_id_rdy;
    w_mem_req_next   = r_mem_req;
    w_mem_addr_next  = r_mem_addr;
    w_byte_cnt_next  = r_byte_cnt;
    if (bus.jump_or_not) begin
      // Redirect squashes a presented instruction and any fetch in flight.
      w_pc_next        = w_jump_pc;
      w_if_id_rdy_next = 1'b0;
      w_mem_req_next   = 1'b0;
      w_byte_cnt_next  = 2'd0;
    end else begin
      case (r_state)
        S_LOOKUP: begin
          if (w_hit) begin
            w_pc_o_next      = r_pc;
            w_inst_o_next    = r_rd_entry[31:0];
            w_if_id_rdy_next = 1'b1;
          end else begin
            w_mem_req_next  = 1'b1;
            w_mem_addr_next = r_pc;
            w_byte_cnt_next = 2'd0;
          end
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            w_byte_cnt_next = r_byte_cnt + 2'd1;
            w_mem_addr_next = r_pc + 32'(r_byte_cnt) + 32'd1;
            if (r_byte_cnt == 2'd3) begin
              w_mem_req_next   = 1'b0;
              w_pc_o_next      = r_pc;
              w_inst_o_next    = w_word;
              w_if_id_rdy_next = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!bus.id_stall) begin
            w_if_id_rdy_next = 1'b0;
            w_pc_next        = r_pc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_pc_o      <= 32'h0;
      r_inst_o    <= 32'h0;
      r_if_id_rdy <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_byte_cnt  <= 2'd0;
      r_rd_valid  <= 1'b0;
    end else if (bus.rdy) begin
      r_pc        <= w_pc_next;
      r_pc_o      <= w_pc_o_next;
      r_inst_o    <= w_inst_o_next;
      r_if_id_rdy <= w_if_id_rdy_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_addr  <= w_mem_addr_next;
      r_byte_cnt  <= w_byte_cnt_next;
      r_rd_valid  <= r_valid[w_rd_idx];
    end
  end

  // ---------------------------------------------------------------- byte assembly lanes
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_buf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_buf[8*gi +: 8] <= 8'h0;
        end else if (bus.rdy && w_byte_ack && (r_byte_cnt == 2'(gi))) begin
          r_buf[8*gi +: 8] <= bus.mem_data;
        end
      end
    end

    // Valid bits need a reset, so they live in flops beside the tag/data RAM.
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid[gi] <= 1'b0;
        end else if (bus.rdy && w_fill && (w_idx == IDX_W'(gi))) begin
          r_valid[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- tag/data RAM, registered read
  always_ff @(posedge clk) begin
    if (bus.rdy) begin
      if (w_fill) begin
        r_cache[w_idx] <= {w_tag, w_word};
      end
      r_rd_entry <= r_cache[w_rd_idx];
    end
  end

  assign bus.pc_o      = r_pc_o;
  assign bus.inst_o    = r_inst_o;
  assign bus.if_id_rdy = r_if_id_rdy;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage
//   Directed bench for if_stage. A byte-memory responder acks each request one
//   cycle after it appears. A compare process checks every cycle against
//   transaction-level rules (byte stepping, word presentation, hold stability,
//   freeze while rdy = 0, presented word equals memory contents), and the main
//   sequence checks hand-computed values for each scenario.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  if_stage_if bus ();

  if_stage #(.ICACHE_INDEX_BITS(7), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic ack_en = 1'b1;

  // Memory image: the first word is hand-written, the rest is a simple formula.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h93;
      32'h1:   return 8'h00;
      32'h2:   return 8'h10;
      32'h3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h5a;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- memory responder
  initial begin
    logic pending;
    pending = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'h0;
    forever begin
      @(negedge clk);
      if (rst || !bus.mem_req || !bus.rdy || !ack_en || bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        pending = 1'b0;
      end else if (!pending) begin
        pending = 1'b1;
      end else begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = mem_byte(bus.mem_addr);
        pending = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- per-cycle rule checker
  logic s_rdy, s_jump, s_stall, s_ack;
  always @(posedge clk) begin
    s_rdy   <= bus.rdy;
    s_jump  <= bus.jump_or_not;
    s_stall <= bus.id_stall;
    s_ack   <= bus.mem_ack;
  end

  initial begin
    logic        pvalid;
    logic [31:0] p_pc, p_inst, p_addr;
    logic        p_rdy, p_req;
    pvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_if_id_rdy", 32'(bus.if_id_rdy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        pvalid = 1'b0;
      end else begin
        if (pvalid) begin
          if (!s_rdy) begin
            chk("frz_pc_o", bus.pc_o, p_pc);
            chk("frz_inst_o", bus.inst_o, p_inst);
            chk("frz_if_id_rdy", 32'(bus.if_id_rdy), 32'(p_rdy));
            chk("frz_mem_req", 32'(bus.mem_req), 32'(p_req));
            chk("frz_mem_addr", bus.mem_addr, p_addr);
          end else if (s_jump) begin
            chk("redir_if_id_rdy", 32'(bus.if_id_rdy), 32'd0);
            chk("redir_mem_req", 32'(bus.mem_req), 32'd0);
          end else if (p_req) begin
            if (!s_ack) begin
              chk("wait_mem_req", 32'(bus.mem_req), 32'd1);
              chk("wait_mem_addr", bus.mem_addr, p_addr);
            end else if (p_addr[1:0] != 2'd3) begin
              chk("step_mem_req", 32'(bus.mem_req), 32'd1);
              chk("step_mem_addr", bus.mem_addr, p_addr + 32'd1);
            end else begin
              chk("done_mem_req", 32'(bus.mem_req), 32'd0);
              chk("done_if_id_rdy", 32'(bus.if_id_rdy), 32'd1);
              chk("done_pc_o", bus.pc_o, {p_addr[31:2], 2'b00});
            end
          end else if (p_rdy) begin
            if (s_stall) begin
              chk("hold_if_id_rdy", 32'(bus.if_id_rdy), 32'd1);
              chk("hold_pc_o", bus.pc_o, p_pc);
              chk("hold_inst_o", bus.inst_o, p_inst);
            end else begin
              chk("accept_if_id_rdy", 32'(bus.if_id_rdy), 32'd0);
              chk("accept_mem_req", 32'(bus.mem_req), 32'd0);
            end
          end else begin
            chk("lookup_excl", 32'(bus.if_id_rdy & bus.mem_req), 32'd0);
            if (bus.mem_req) chk("lookup_align", 32'(bus.mem_addr[1:0]), 32'd0);
          end
        end
        if (bus.if_id_rdy) chk("inst_vs_mem", bus.inst_o, mem_word(bus.pc_o));
        p_pc   = bus.pc_o;
        p_inst = bus.inst_o;
        p_rdy  = bus.if_id_rdy;
        p_req  = bus.mem_req;
        p_addr = bus.mem_addr;
        pvalid = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- directed helpers
  task automatic wait_addr(input logic [31:0] t, input string name);
    for (int i = 0; i < 50 && !(bus.mem_req && bus.mem_addr == t); i++) tick();
    chk(name, bus.mem_addr, t);
  endtask

  // Called while a fetch is in flight; records the distinct byte addresses
  // requested until the word is presented.
  task automatic fetch_word(input logic [31:0] base, input string name);
    logic [31:0] seq[$];
    logic [31:0] last;
    seq.push_back(bus.mem_addr);
    last = bus.mem_addr;
    for (int k = 0; k < 60 && !bus.if_id_rdy; k++) begin
      tick();
      if (bus.mem_req && bus.mem_addr != last) begin
        seq.push_back(bus.mem_addr);
        last = bus.mem_addr;
      end
    end
    chk({name, "_presented"}, 32'(bus.if_id_rdy), 32'd1);
    chk({name, "_nbytes"}, 32'(seq.size()), 32'd4);
    foreach (seq[i]) chk({name, "_addr"}, seq[i], base + 32'(i));
    chk({name, "_pc_o"}, bus.pc_o, base);
    chk({name, "_mem_req"}, 32'(bus.mem_req), 32'd0);
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    bus.rdy         = 1'b1;
    bus.jump_or_not = 1'b0;
    bus.jump_addr   = 32'h0;
    bus.id_stall    = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc_o", bus.pc_o, 32'h0);
    chk("reset_inst_o", bus.inst_o, 32'h0);
    chk("reset_if_id_rdy", 32'(bus.if_id_rdy), 32'd0);
    chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;

    // Reset then miss at pc 0
    tick();
    chk("miss0_req", 32'(bus.mem_req), 32'd1);
    chk("miss0_first_addr", bus.mem_addr, 32'h0);
    fetch_word(32'h0, "miss0");
    chk("miss0_inst", bus.inst_o, 32'h00100093);
    $display("txn miss pc=%h inst=%h", bus.pc_o, bus.inst_o);

    // Back-pressure: five stalled cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_if_id_rdy", 32'(bus.if_id_rdy), 32'd1);
      chk("stall_pc_o", bus.pc_o, 32'h0);
      chk("stall_inst_o", bus.inst_o, 32'h00100093);
    end
    bus.id_stall = 1'b0;
    tick();
    bus.id_stall = 1'b1;
    chk("accept_rdy_low", 32'(bus.if_id_rdy), 32'd0);
    tick();
    chk("next_pc4_req", 32'(bus.mem_req), 32'd1);
    chk("next_pc4_addr", bus.mem_addr, 32'h4);
    $display("txn accept -> lookup pc=%h", bus.mem_addr);

    // Cache hit: redirect to 0 while fetching pc 4
    bus.jump_or_not = 1'b1;
    bus.jump_addr   = 32'h0;
    tick();
    bus.jump_or_not = 1'b0;
    chk("hit_redir_rdy", 32'(bus.if_id_rdy), 32'd0);
    chk("hit_redir_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("hit_rdy", 32'(bus.if_id_rdy), 32'd1);
    chk("hit_pc_o", bus.pc_o, 32'h0);
    chk("hit_inst", bus.inst_o, 32'h00100093);
    chk("hit_no_req", 32'(bus.mem_req), 32'd0);
    $display("txn hit pc=%h inst=%h", bus.pc_o, bus.inst_o);

    // Redirect in the same cycle as acceptance
    bus.id_stall    = 1'b0;
    bus.jump_or_not = 1'b1;
    bus.jump_addr   = 32'h200;
    tick();
    bus.jump_or_not = 1'b0;
    bus.id_stall    = 1'b1;
    chk("squash_rdy", 32'(bus.if_id_rdy), 32'd0);
    tick();
    chk("squash_req", 32'(bus.mem_req), 32'd1);
    chk("squash_addr", bus.mem_addr, 32'h200);
    $display("txn redirect-on-accept -> pc=%h", bus.mem_addr);

    // Redirect mid-fetch after two acks (target low bits dropped)
    wait_addr(32'h202, "mid_two_acks");
    bus.jump_or_not = 1'b1;
    bus.jump_addr   = 32'h1003;
    tick();
    bus.jump_or_not = 1'b0;
    chk("mid_req_drop", 32'(bus.mem_req), 32'd0);
    tick();
    chk("mid_new_req", 32'(bus.mem_req), 32'd1);
    chk("mid_new_addr", bus.mem_addr, 32'h1000);
    // Abandon this one too: 0x1000 must still miss afterwards
    wait_addr(32'h1002, "mid2_two_acks");
    bus.jump_or_not = 1'b1;
    bus.jump_addr   = 32'h1000;
    tick();
    bus.jump_or_not = 1'b0;
    chk("mid2_req_drop", 32'(bus.mem_req), 32'd0);
    tick();
    chk("mid2_still_miss", 32'(bus.mem_req), 32'd1);
    chk("mid2_addr", bus.mem_addr, 32'h1000);
    fetch_word(32'h1000, "fresh1000");
    chk("fresh1000_inst", bus.inst_o, 32'h49484b4a);
    $display("txn miss pc=%h inst=%h", bus.pc_o, bus.inst_o);

    // rdy low mid-fetch, then asynchronous reset
    bus.id_stall = 1'b0;
    tick();
    bus.id_stall = 1'b1;
    wait_addr(32'h1005, "frz_one_ack");
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_req_held", 32'(bus.mem_req), 32'd1);
      chk("frz_addr_held", bus.mem_addr, 32'h1005);
      chk("frz_rdy_held", 32'(bus.if_id_rdy), 32'd0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("arst_if_id_rdy", 32'(bus.if_id_rdy), 32'd0);
    chk("arst_pc_o", bus.pc_o, 32'h0);
    chk("arst_mem_addr", bus.mem_addr, 32'h0);
    #2;
    rst = 1'b0;
    bus.rdy = 1'b1;
    tick();
    chk("restart_req", 32'(bus.mem_req), 32'd1);
    chk("restart_addr", bus.mem_addr, 32'h0);
    fetch_word(32'h0, "restart");
    chk("restart_inst", bus.inst_o, 32'h00100093);
    $display("txn restart pc=%h inst=%h", bus.pc_o, bus.inst_o);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
